// File: rtl/br_resolve_ctrl.sv
// In-order branch resolution: FIFO of IF predictions retired by EX. The predictor update, flush and redirect are registered one cycle after the pop.
// Backpressure: fe_ready drops when the FIFO is full and during the flush/recover window, while ex_valid is ignored in that window.

module br_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
endmodule

module br_resolve_ctrl #(
    parameter int DEPTH       = 4,
    parameter int IDX_W       = 3,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pc_en,
    input  logic             fe_valid,
    input  logic [IDX_W-1:0] fe_index,
    input  logic             fe_predict,
    input  logic [31:0]      fe_target,
    input  logic [31:0]      fe_npc,
    output logic             fe_ready,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             upd_en,
    output logic [IDX_W-1:0] upd_index,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic             flush,
    output logic             redirect_en,
    output logic [31:0]      redirect_pc,
    output logic             pop_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);
    localparam int RW = (RECOVER_CYC > 2) ? $clog2(RECOVER_CYC) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             predict;
        logic [31:0]      target;
        logic [31:0]      npc;
    } ent_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    ent_t          head_dat, push_dat;
    logic          full, empty;
    logic          do_push, do_pop, mispred, kill, pop_empty;

    assign fe_ready  = !full && (state == RUN) && !RST;
    assign do_pop    = ex_valid && pc_en && (state == RUN) && !empty;
    assign pop_empty = ex_valid && pc_en && (state == RUN) && empty;
    assign mispred   = (head_dat.predict != ex_taken) ||
                       (ex_taken && (head_dat.target != ex_target));
    assign kill      = do_pop && mispred;
    // Wrong-path push in the mispredict cycle is dropped along with the whole FIFO.
    assign do_push   = fe_valid && fe_ready && pc_en && !kill;
    assign push_dat  = '{index: fe_index, predict: fe_predict, target: fe_target, npc: fe_npc};

    br_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (kill),
        .push     (do_push),
        .push_dat (push_dat),
        .pop      (do_pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        case (state)
            RUN:     if (kill) state_nxt = FLUSH;
            FLUSH: begin
                state_nxt = RECOVER;
                rcnt_nxt  = RW'(RECOVER_CYC - 1);
            end
            RECOVER: begin
                if (rcnt == '0) state_nxt = RUN;
                else            rcnt_nxt  = rcnt - RW'(1);
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            upd_en      <= 1'b0;
            upd_index   <= '0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            flush       <= 1'b0;
            redirect_en <= 1'b0;
            redirect_pc <= '0;
            pop_err     <= 1'b0;
            br_cnt      <= '0;
            mis_cnt     <= '0;
        end else begin
            upd_en      <= do_pop;
            upd_index   <= do_pop ? head_dat.index : '0;
            upd_taken   <= do_pop && ex_taken;
            upd_target  <= do_pop ? ex_target : '0;
            flush       <= kill;
            redirect_en <= kill;
            redirect_pc <= do_pop ? (ex_taken ? ex_target : head_dat.npc) : '0;
            if (pop_empty) pop_err <= 1'b1;
            if (do_pop && !(&br_cnt)) br_cnt <= br_cnt + CNT_W'(1);
            if (kill && !(&mis_cnt)) mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Randomized plus directed bench for br_resolve_ctrl with a queue-based reference model and scoreboard.
module tb_br_resolve_ctrl;
    localparam int DEPTH = 4;
    localparam int RC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pc_en = 1'b0, fe_valid = 1'b0, fe_predict = 1'b0;
    logic [2:0]  fe_index = '0;
    logic [31:0] fe_target = '0, fe_npc = '0;
    logic        fe_ready;
    logic        ex_valid = 1'b0, ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        upd_en, upd_taken, flush, redirect_en, pop_err;
    logic [2:0]  upd_index;
    logic [31:0] upd_target, redirect_pc;
    logic [CW-1:0] br_cnt, mis_cnt;

    br_resolve_ctrl #(.DEPTH(DEPTH), .IDX_W(3), .RECOVER_CYC(RC), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .pc_en(pc_en), .fe_valid(fe_valid), .fe_index(fe_index),
        .fe_predict(fe_predict), .fe_target(fe_target), .fe_npc(fe_npc), .fe_ready(fe_ready),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
        .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .pop_err(pop_err), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  idx;
        bit          pred;
        logic [31:0] tgt;
        logic [31:0] npc;
    } ent_t;

    typedef struct {
        logic [2:0]  idx;
        bit          taken;
        logic [31:0] tgt;
        bit          mis;
        logic [31:0] rpc;
        int          br;
        int          mc;
    } exp_t;

    ent_t q[$];
    exp_t exp_q[$];
    int   m_hold = 0, m_br = 0, m_mis = 0;
    bit   m_perr = 1'b0;
    bit   mon_on = 1'b0;
    int   tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle: check registered state, drive inputs, advance the model, wait for the next negedge.
    task automatic cyc(input bit r, input bit pe, input bit fv, input logic [2:0] fi, input bit fp,
                       input logic [31:0] ft, input logic [31:0] fn,
                       input bit xv, input bit xt, input logic [31:0] xtg);
        bit   rdy, run, pop, mis;
        ent_t h, n;
        exp_t e;
        chk("pop_err", {31'b0, pop_err}, {31'b0, m_perr});
        chk("br_cnt", 32'(br_cnt), 32'(m_br));
        chk("mis_cnt", 32'(mis_cnt), 32'(m_mis));
        RST = r; pc_en = pe; fe_valid = fv; fe_index = fi; fe_predict = fp;
        fe_target = ft; fe_npc = fn; ex_valid = xv; ex_taken = xt; ex_target = xtg;
        #1;
        rdy = !r && (m_hold == 0) && (q.size() < DEPTH);
        chk("fe_ready", {31'b0, fe_ready}, {31'b0, rdy});
        if (r) begin
            q.delete();
            m_hold = 0; m_perr = 1'b0; m_br = 0; m_mis = 0;
        end else begin
            run = (m_hold == 0);
            pop = xv && pe && run && (q.size() > 0);
            mis = 1'b0;
            if (xv && pe && run && q.size() == 0) m_perr = 1'b1;
            if (pop) begin
                h   = q[0];
                mis = (h.pred != xt) || (xt && h.tgt != xtg);
                if (m_br < CMAX) m_br++;
                if (mis && m_mis < CMAX) m_mis++;
                e.idx = h.idx; e.taken = xt; e.tgt = xtg; e.mis = mis;
                e.rpc = xt ? xtg : h.npc; e.br = m_br; e.mc = m_mis;
                exp_q.push_back(e);
                if (mis) q.delete();
                else void'(q.pop_front());
            end
            if (fv && rdy && pe && !mis) begin
                n.idx = fi; n.pred = fp; n.tgt = ft; n.npc = fn;
                q.push_back(n);
            end
            if (mis) m_hold = 1 + RC;
            else if (m_hold > 0) m_hold--;
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (mon_on) begin
            if (upd_en) begin
                if (exp_q.size() == 0) begin
                    chk("upd_unexpected", {31'b0, upd_en}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_index", 32'(upd_index), 32'(e.idx));
                    chk("upd_taken", {31'b0, upd_taken}, {31'b0, e.taken});
                    chk("upd_target", upd_target, e.tgt);
                    chk("flush", {31'b0, flush}, {31'b0, e.mis});
                    chk("redirect_en", {31'b0, redirect_en}, {31'b0, e.mis});
                    if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
                    chk("upd_br_cnt", 32'(br_cnt), 32'(e.br));
                    chk("upd_mis_cnt", 32'(mis_cnt), 32'(e.mc));
                end
            end else begin
                chk("flush_idle", {31'b0, flush}, 32'd0);
                chk("redirect_idle", {31'b0, redirect_en}, 32'd0);
            end
        end
    end

    initial begin
        bit r, pe, fv, fp, xv, xt;
        logic [2:0]  fi;
        logic [31:0] ft, fn, xtg;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        mon_on = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Correct not-taken prediction.
        cyc(0, 1, 1, 3, 0, 0, 32'h104, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Not-taken predicted, taken actual.
        cyc(0, 1, 1, 5, 0, 0, 32'h208, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h300);
        idle(5);
        // Target mismatch, then taken predicted but not taken.
        cyc(0, 1, 1, 1, 1, 32'h400, 32'h50c, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h480);
        idle(4);
        cyc(0, 1, 1, 2, 1, 32'h400, 32'h510, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(4);
        // Fill, overflow attempt, simultaneous push/pop, in-order drain.
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 3'(i), 0, 0, 32'h600 + 32'(4*i), 0, 0, 0);
        cyc(0, 1, 1, 6, 0, 0, 32'h700, 1, 0, 0);
        cyc(0, 1, 1, 7, 0, 0, 32'h704, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Mispredict with a concurrent push, then ex_valid during recovery.
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 3'(i+4), 1, 32'h800, 32'h900 + 32'(4*i), 0, 0, 0);
        cyc(0, 1, 1, 7, 1, 32'h800, 32'h990, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Pop from empty, stalled pipeline, reset during recovery.
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 2, 0, 0, 32'ha04, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3, 1, 32'hb00, 32'hb04, 1, 1, 32'hc00);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'hc00);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 32'hd04, 1, 0, 0);
        idle(2);
        // Randomized traffic including saturation and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            pe  = ($urandom_range(0, 99) < 85);
            fv  = ($urandom_range(0, 99) < 60);
            xv  = ($urandom_range(0, 99) < 40);
            fi  = 3'($urandom_range(0, 7));
            fp  = 1'($urandom_range(0, 1));
            ft  = $urandom_range(0, 1) ? 32'h400 : 32'h480;
            fn  = 32'($urandom_range(0, 1023)) << 2;
            if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
                xt  = q[0].pred;
                xtg = q[0].tgt;
            end else begin
                xt  = 1'($urandom_range(0, 1));
                xtg = $urandom_range(0, 1) ? 32'h400 : 32'h480;
            end
            cyc(r, pe, fv, fi, fp, ft, fn, xv, xt, xtg);
        end
        idle(6);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
